// File: rtl/ex_mem_stage_pipe_if.sv
// EX/MEM stage bus: ID/EX operands and controls, write-back forwarding source,
// and the registered EX/MEM outputs.
//   master : drives the ID/EX side, stall/flush and write-back inputs; observes outputs
//   slave  : the execute stage itself
interface ex_mem_stage_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA    = 5
);
    // ID/EX side
    logic             in_valid;
    logic             stall_in;
    logic             flush;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] imm;
    logic [RA-1:0]    rs;
    logic [RA-1:0]    rt;
    logic [RA-1:0]    rd;
    logic             reg_write;
    logic             alu_src;
    logic             reg_dst;
    logic             mem_write;
    logic             mem_read;
    logic             mem_to_reg;
    logic [2:0]       alu_op;
    // MEM/WB forwarding source
    logic             wb_reg_write;
    logic [RA-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    // EX/MEM register outputs
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] wdata_q;
    logic [RA-1:0]    dst_q;
    logic             zero_q;
    logic             valid_q;
    logic             reg_write_q;
    logic             mem_write_q;
    logic             mem_read_q;
    logic             mem_to_reg_q;
    logic             busy;

    modport master (
        output in_valid, stall_in, flush, data1, data2, imm, rs, rt, rd,
               reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg, alu_op,
               wb_reg_write, wb_rd, wb_data,
        input  alu_q, wdata_q, dst_q, zero_q, valid_q, reg_write_q, mem_write_q,
               mem_read_q, mem_to_reg_q, busy
    );

    modport slave (
        input  in_valid, stall_in, flush, data1, data2, imm, rs, rt, rd,
               reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg, alu_op,
               wb_reg_write, wb_rd, wb_data,
        output alu_q, wdata_q, dst_q, zero_q, valid_q, reg_write_q, mem_write_q,
               mem_read_q, mem_to_reg_q, busy
    );
endinterface

// File: rtl/ex_mem_stage_pipe.sv
// Execute stage plus EX/MEM pipeline register for the MIPS pipeline.
// Two-level operand forwarding (EX/MEM over MEM/WB), single-cycle ALU ops and an
// iterative shift-add multiplier that holds busy high while it runs.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of ex_mem_stage_pipe_if (ID/EX inputs, WB forwarding, EX/MEM outputs)
module ex_mem_stage_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA    = 5
) (
    input logic                 clk,
    input logic                 rst,
    ex_mem_stage_pipe_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StMul  = 1'b1;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpMul = 3'b011;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpSlt = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mwdata_q, mwdata_d;
    logic [RA-1:0]    mdst_q, mdst_d;
    logic [3:0]       mctrl_q, mctrl_d;   // {reg_write, mem_write, mem_read, mem_to_reg}

    logic [WIDTH-1:0] alu_d, wdata_d;
    logic [RA-1:0]    dst_d;
    logic             zero_d, valid_d;
    logic [3:0]       ctrl_d;

    logic             ex_fwd_ok, ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
    logic [WIDTH-1:0] op_a, op_b, alu_b, alu_res, acc_step;
    logic [RA-1:0]    dst_sel;
    logic [3:0]       ctrl_in;

    // A load's EX/MEM value is an address, not the loaded data, so it never forwards.
    assign ex_fwd_ok = bus.valid_q & bus.reg_write_q & ~bus.mem_read_q & (bus.dst_q != '0);
    assign ex_hit_a  = ex_fwd_ok & (bus.dst_q == bus.rs);
    assign ex_hit_b  = ex_fwd_ok & (bus.dst_q == bus.rt);
    assign wb_hit_a  = bus.wb_reg_write & (bus.wb_rd != '0) & (bus.wb_rd == bus.rs);
    assign wb_hit_b  = bus.wb_reg_write & (bus.wb_rd != '0) & (bus.wb_rd == bus.rt);

    assign op_a    = ex_hit_a ? bus.alu_q : (wb_hit_a ? bus.wb_data : bus.data1);
    assign op_b    = ex_hit_b ? bus.alu_q : (wb_hit_b ? bus.wb_data : bus.data2);
    assign alu_b   = bus.alu_src ? bus.imm : op_b;
    assign dst_sel = bus.reg_dst ? bus.rd : bus.rt;
    assign ctrl_in = {bus.reg_write, bus.mem_write, bus.mem_read, bus.mem_to_reg};

    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign bus.busy = (state_q == StMul);

    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            OpAnd:   alu_res = op_a & alu_b;
            OpOr:    alu_res = op_a | alu_b;
            OpAdd:   alu_res = op_a + alu_b;
            OpSub:   alu_res = op_a - alu_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mwdata_d = mwdata_q;
        mdst_d   = mdst_q;
        mctrl_d  = mctrl_q;
        // Hold the output register unless a bubble or result is loaded below.
        alu_d    = bus.alu_q;
        wdata_d  = bus.wdata_q;
        dst_d    = bus.dst_q;
        zero_d   = bus.zero_q;
        valid_d  = bus.valid_q;
        ctrl_d   = {bus.reg_write_q, bus.mem_write_q, bus.mem_read_q, bus.mem_to_reg_q};

        if (bus.flush) begin
            // Flush beats stall and abandons any multiply in flight.
            state_d = StIdle;
            cnt_d   = '0;
            alu_d   = '0;
            wdata_d = '0;
            dst_d   = '0;
            zero_d  = 1'b0;
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!bus.stall_in) begin
            alu_d   = '0;
            wdata_d = '0;
            dst_d   = '0;
            zero_d  = 1'b0;
            valid_d = 1'b0;
            ctrl_d  = '0;
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        if (bus.alu_op == OpMul) begin
                            mcand_d  = op_a;
                            mplier_d = alu_b;
                            mwdata_d = op_b;
                            mdst_d   = dst_sel;
                            mctrl_d  = ctrl_in;
                            acc_d    = '0;
                            cnt_d    = CW'(WIDTH);
                            state_d  = StMul;
                        end else begin
                            alu_d   = alu_res;
                            wdata_d = op_b;
                            dst_d   = dst_sel;
                            zero_d  = (alu_res == '0);
                            valid_d = 1'b1;
                            ctrl_d  = ctrl_in;
                        end
                    end
                end
                StMul: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        alu_d   = acc_step;
                        wdata_d = mwdata_q;
                        dst_d   = mdst_q;
                        zero_d  = (acc_step == '0);
                        valid_d = 1'b1;
                        ctrl_d  = mctrl_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            acc_q            <= '0;
            mcand_q          <= '0;
            mplier_q         <= '0;
            mwdata_q         <= '0;
            mdst_q           <= '0;
            mctrl_q          <= '0;
            bus.alu_q        <= '0;
            bus.wdata_q      <= '0;
            bus.dst_q        <= '0;
            bus.zero_q       <= 1'b0;
            bus.valid_q      <= 1'b0;
            bus.reg_write_q  <= 1'b0;
            bus.mem_write_q  <= 1'b0;
            bus.mem_read_q   <= 1'b0;
            bus.mem_to_reg_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            acc_q            <= acc_d;
            mcand_q          <= mcand_d;
            mplier_q         <= mplier_d;
            mwdata_q         <= mwdata_d;
            mdst_q           <= mdst_d;
            mctrl_q          <= mctrl_d;
            bus.alu_q        <= alu_d;
            bus.wdata_q      <= wdata_d;
            bus.dst_q        <= dst_d;
            bus.zero_q       <= zero_d;
            bus.valid_q      <= valid_d;
            bus.reg_write_q  <= ctrl_d[3];
            bus.mem_write_q  <= ctrl_d[2];
            bus.mem_read_q   <= ctrl_d[1];
            bus.mem_to_reg_q <= ctrl_d[0];
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_pipe.sv
// Scoreboard bench for ex_mem_stage_pipe: directed instructions push expected
// EX/MEM contents (including the cycle they must appear); a monitor pops and
// compares on every valid_q.
module tb_ex_mem_stage_pipe;

    localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010, MUL = 3'b011;
    localparam logic [2:0] SUB = 3'b110, SLT = 3'b111, BAD = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_mem_stage_pipe_if #(.WIDTH(32), .RA(5)) bus ();

    ex_mem_stage_pipe #(.WIDTH(32), .RA(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic        zero;
        logic [3:0]  ctrl;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   miss = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation.
    exp_t e;
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.valid_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected valid_q", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("alu_q", bus.alu_q, e.alu);
                chk("wdata_q", bus.wdata_q, e.wdata);
                chk("dst_q", {27'd0, bus.dst_q}, {27'd0, e.dst});
                chk("zero_q", {31'd0, bus.zero_q}, {31'd0, e.zero});
                chk("ctrl_q", {28'd0, bus.reg_write_q, bus.mem_write_q, bus.mem_read_q,
                               bus.mem_to_reg_q}, {28'd0, e.ctrl});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] im, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic src, input logic rdst,
                         input logic [3:0] ctrl);
        bus.alu_op     = op;
        bus.data1      = d1;
        bus.data2      = d2;
        bus.imm        = im;
        bus.rs         = s;
        bus.rt         = t;
        bus.rd         = d;
        bus.alu_src    = src;
        bus.reg_dst    = rdst;
        {bus.reg_write, bus.mem_write, bus.mem_read, bus.mem_to_reg} = ctrl;
        bus.in_valid   = 1'b1;
    endtask

    task automatic expect_res(input logic [31:0] alu, input logic [31:0] wdata,
                              input logic [4:0] dst, input logic [3:0] ctrl, input int lat);
        exp_t x;
        x.alu   = alu;
        x.wdata = wdata;
        x.dst   = dst;
        x.zero  = (alu == 32'd0);
        x.ctrl  = ctrl;
        x.cyc   = cyc + lat;
        exp_q.push_back(x);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " busy"}, {31'd0, bus.busy}, 32'd0);
        chk({name, " valid_q"}, {31'd0, bus.valid_q}, 32'd0);
    endtask

    initial begin
        bus.in_valid = 0; bus.stall_in = 0; bus.flush = 0;
        bus.data1 = 0; bus.data2 = 0; bus.imm = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
        bus.reg_write = 0; bus.alu_src = 0; bus.reg_dst = 0; bus.mem_write = 0;
        bus.mem_read = 0; bus.mem_to_reg = 0; bus.alu_op = 0;
        bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;

        // Reset state
        repeat (2) step();
        chk("rst alu_q", bus.alu_q, 32'd0);
        chk("rst wdata_q", bus.wdata_q, 32'd0);
        chk("rst dst_q", {27'd0, bus.dst_q}, 32'd0);
        chk("rst flags", {26'd0, bus.zero_q, bus.valid_q, bus.reg_write_q, bus.mem_write_q,
                          bus.mem_read_q, bus.mem_to_reg_q}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        idle(2);

        // ADD immediate: 5 + 7
        drive(ADD, 32'd5, 32'd0, 32'd7, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 4'b1000);
        expect_res(32'd12, 32'd0, 5'd1, 4'b1000, 1);
        step();
        idle(2);

        // r3 = 10 + 20, then r4 = r3 - r3 with stale register file values
        drive(ADD, 32'd10, 32'd20, 32'd0, 5'd5, 5'd6, 5'd3, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd30, 32'd20, 5'd3, 4'b1000, 1);
        step();
        drive(SUB, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd0, 32'd30, 5'd4, 4'b1000, 1);
        step();
        idle(2);

        // Same pair with a conflicting MEM/WB write to r3: EX/MEM must win
        drive(ADD, 32'd10, 32'd20, 32'd0, 5'd5, 5'd6, 5'd3, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd30, 32'd20, 5'd3, 4'b1000, 1);
        step();
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd9;
        drive(SUB, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd0, 32'd30, 5'd4, 4'b1000, 1);
        step();
        bus.wb_reg_write = 1'b0;
        idle(2);

        // MEM/WB forwarding alone on A; then wb_rd=0 must not forward
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hF0;
        drive(OR_, 32'd1, 32'h0F, 32'd0, 5'd7, 5'd0, 5'd2, 1'b0, 1'b1, 4'b1000);
        expect_res(32'hFF, 32'h0F, 5'd2, 4'b1000, 1);
        step();
        bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
        drive(AND_, 32'hFF, 32'h0F, 32'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 4'b1000);
        expect_res(32'h0F, 32'h0F, 5'd5, 4'b1000, 1);
        step();
        bus.wb_reg_write = 1'b0;
        idle(2);

        // Load into r8 must not forward its address to the next instruction
        drive(ADD, 32'd100, 32'h11, 32'd4, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 4'b1011);
        expect_res(32'd104, 32'h11, 5'd8, 4'b1011, 1);
        step();
        drive(ADD, 32'd1, 32'd0, 32'd1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 4'b1000);
        expect_res(32'd2, 32'd0, 5'd9, 4'b1000, 1);
        step();
        // r10 = 0x1234, then store r10: store data is forwarded
        drive(ADD, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 4'b1000);
        expect_res(32'h1234, 32'd0, 5'd10, 4'b1000, 1);
        step();
        drive(ADD, 32'h40, 32'hAB, 32'd8, 5'd0, 5'd10, 5'd0, 1'b1, 1'b0, 4'b0100);
        expect_res(32'h48, 32'h1234, 5'd10, 4'b0100, 1);
        step();
        idle(2);

        // Signed SLT both ways, and an undefined opcode
        drive(SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd1, 32'd1, 5'd11, 4'b1000, 1);
        step();
        drive(SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd0, 32'hFFFF_FFFF, 5'd11, 4'b1000, 1);
        step();
        drive(BAD, 32'd3, 32'd4, 32'd0, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd0, 32'd4, 5'd11, 4'b1000, 1);
        step();
        idle(2);

        // MUL 0xFFFFFFFF * 3: busy for 32 cycles, result 33 cycles after issue
        drive(MUL, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd0, 5'd0, 5'd12, 1'b0, 1'b1, 4'b1000);
        expect_res(32'hFFFF_FFFD, 32'd3, 5'd12, 4'b1000, 33);
        step();
        for (int i = 0; i < 32; i++) begin
            // An instruction offered while busy is ignored
            if (i == 0) drive(ADD, 32'd1, 32'd1, 32'd1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 4'b1000);
            if (i == 3) bus.in_valid = 1'b0;
            chk("mul busy", {31'd0, bus.busy}, 32'd1);
            chk("mul valid_q low", {31'd0, bus.valid_q}, 32'd0);
            step();
        end
        chk("mul busy after", {31'd0, bus.busy}, 32'd0);
        idle(2);

        // MUL 7 * imm 6 with a 4-cycle stall in the middle
        drive(MUL, 32'd7, 32'd0, 32'd6, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 4'b1000);
        expect_res(32'd42, 32'd0, 5'd14, 4'b1000, 37);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        bus.stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall busy", {31'd0, bus.busy}, 32'd1);
            chk("stall alu_q", bus.alu_q, 32'd0);
            chk("stall valid_q", {31'd0, bus.valid_q}, 32'd0);
        end
        bus.stall_in = 1'b0;
        repeat (22) step();
        chk("stall mul done busy", {31'd0, bus.busy}, 32'd0);
        idle(2);

        // Flush mid-MUL: aborted, nothing emitted
        drive(MUL, 32'd5, 32'd5, 32'd0, 5'd0, 5'd0, 5'd15, 1'b0, 1'b1, 4'b1000);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk_quiet("flush");
        idle(40);

        // Flush together with stall: flush wins
        drive(MUL, 32'd5, 32'd5, 32'd0, 5'd0, 5'd0, 5'd15, 1'b0, 1'b1, 4'b1000);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        bus.flush = 1'b1; bus.stall_in = 1'b1;
        step();
        bus.flush = 1'b0; bus.stall_in = 1'b0;
        chk_quiet("flush+stall");
        idle(40);

        // Asynchronous reset mid-MUL, then a normal ADD
        drive(MUL, 32'd5, 32'd5, 32'd0, 5'd0, 5'd0, 5'd15, 1'b0, 1'b1, 4'b1000);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        chk("pre-rst busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_quiet("async rst");
        chk("async rst alu_q", bus.alu_q, 32'd0);
        step();
        rst = 1'b1;
        step();
        drive(ADD, 32'd2, 32'd3, 32'd0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 4'b1000);
        expect_res(32'd5, 32'd3, 5'd6, 4'b1000, 1);
        step();
        idle(40);

        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
